// File: rtl/axis_stream_transform_fifo.sv
// axis_stream_transform_fifo: per-packet AXI-Stream transform (pass, byte reverse, add, XOR) feeding an output FIFO
// Ports: aclk/aresetn (sync, active low); s_axis_* input stream; m_axis_* output stream;
//        mode/constant_value select and parameterise the transform; active_mode, pkt_count,
//        beat_count and fifo_level report status.
module axis_stream_transform_fifo #(
  parameter int TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [TDATA_WIDTH-1:0]          s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0]        s_axis_tkeep,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [TDATA_WIDTH-1:0]          m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0]        m_axis_tkeep,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  input  logic [1:0]                      mode,
  input  logic [TDATA_WIDTH-1:0]          constant_value,
  output logic [1:0]                      active_mode,
  output logic [CNT_WIDTH-1:0]            pkt_count,
  output logic [CNT_WIDTH-1:0]            beat_count,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);
  localparam int KW = TDATA_WIDTH / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, IN_PKT} state_t;
  state_t state, state_nxt;
  logic [TDATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [KW-1:0]          keep_mem [FIFO_DEPTH];
  logic                   last_mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic                   push, pop;
  logic [1:0]             eff_mode;
  logic [TDATA_WIDTH-1:0] rev_data, t_data;
  logic [KW-1:0]          rev_keep, t_keep;
  // Occupancy never exceeds FIFO_DEPTH (a power of two), so its top bit is the full flag.
  assign s_axis_tready = !fifo_level[AW] && aresetn;
  assign m_axis_tvalid = |fifo_level;
  assign push = s_axis_tvalid && s_axis_tready;
  assign pop  = m_axis_tvalid && m_axis_tready;
  // Head is masked when empty so the outputs read zero after reset without clearing the storage.
  assign m_axis_tdata = m_axis_tvalid ? data_mem[rd_ptr] : '0;
  assign m_axis_tkeep = m_axis_tvalid ? keep_mem[rd_ptr] : '0;
  assign m_axis_tlast = m_axis_tvalid && last_mem[rd_ptr];
  always_comb begin
    state_nxt = state;
    eff_mode  = (state == IDLE) ? mode : active_mode;
    if (push) state_nxt = s_axis_tlast ? IDLE : IN_PKT;
  end
  always_comb begin
    rev_data = '0;
    rev_keep = '0;
    for (int i = 0; i < KW; i++) begin
      rev_data[8*i +: 8] = s_axis_tdata[8*(KW-1-i) +: 8];
      rev_keep[i]        = s_axis_tkeep[KW-1-i];
    end
    t_data = (eff_mode == 2'd0) ? s_axis_tdata :
             (eff_mode == 2'd1) ? rev_data :
             (eff_mode == 2'd2) ? s_axis_tdata + constant_value :
                                  s_axis_tdata ^ constant_value;
    t_keep = (eff_mode == 2'd1) ? rev_keep : s_axis_tkeep;
  end
  always_ff @(posedge aclk) begin
    if (push) begin
      data_mem[wr_ptr] <= t_data;
      keep_mem[wr_ptr] <= t_keep;
      last_mem[wr_ptr] <= s_axis_tlast;
    end
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      active_mode <= '0;
      pkt_count   <= '0;
      beat_count  <= '0;
    end else begin
      state      <= state_nxt;
      fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        pkt_count  <= pkt_count + CNT_WIDTH'(s_axis_tlast);
        beat_count <= s_axis_tlast ? '0 : beat_count + 1'b1;
        if (state == IDLE) active_mode <= mode;
      end
    end
  end
endmodule

// File: tb/tb_axis_stream_transform_fifo.sv
// tb_axis_stream_transform_fifo: directed table-driven bench for axis_stream_transform_fifo
module tb_axis_stream_transform_fifo;
  logic        clk = 0;
  logic        aresetn = 0;
  logic [31:0] s_data = '0;
  logic [3:0]  s_keep = '0;
  logic        s_valid = 0, s_last = 0, s_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid, m_last, m_ready = 0;
  logic [1:0]  mode = '0, active_mode;
  logic [31:0] cval = '0;
  logic [15:0] pkt_count, beat_count;
  logic [2:0]  fifo_level;
  int n = 0, errs = 0;

  axis_stream_transform_fifo dut (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
    .s_axis_tlast(s_last), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
    .m_axis_tlast(m_last), .m_axis_tready(m_ready),
    .mode(mode), .constant_value(cval), .active_mode(active_mode),
    .pkt_count(pkt_count), .beat_count(beat_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [31:0] cval;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    logic        exp_last;
    logic [1:0]  exp_active;
    logic [15:0] exp_pkt;
    logic [15:0] exp_beat;
  } vec_t;
  vec_t vecs[10];

  initial begin
    int got, nxt;
    logic acc;
    vecs[0] = '{2'd0, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0,        32'hDEADBEEF, 4'hF, 1'b1, 2'd0, 16'd1, 16'd0};
    vecs[1] = '{2'd1, 32'h11223344, 4'h3, 1'b0, 32'h0,        32'h44332211, 4'hC, 1'b0, 2'd1, 16'd1, 16'd1};
    vecs[2] = '{2'd2, 32'hAABBCCDD, 4'hF, 1'b1, 32'h0,        32'hDDCCBBAA, 4'hF, 1'b1, 2'd1, 16'd2, 16'd0};
    vecs[3] = '{2'd2, 32'h00000005, 4'hF, 1'b0, 32'h0000000A, 32'h0000000F, 4'hF, 1'b0, 2'd2, 16'd2, 16'd1};
    vecs[4] = '{2'd2, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0000000A, 32'h00000009, 4'hF, 1'b1, 2'd2, 16'd3, 16'd0};
    vecs[5] = '{2'd3, 32'h12345678, 4'hF, 1'b1, 32'hFFFF0000, 32'hEDCB5678, 4'hF, 1'b1, 2'd3, 16'd4, 16'd0};
    vecs[6] = '{2'd1, 32'h01020304, 4'h0, 1'b1, 32'h0,        32'h04030201, 4'h0, 1'b1, 2'd1, 16'd5, 16'd0};
    vecs[7] = '{2'd1, 32'hA0B0C0D0, 4'h1, 1'b1, 32'h0,        32'hD0C0B0A0, 4'h8, 1'b1, 2'd1, 16'd6, 16'd0};
    vecs[8] = '{2'd0, 32'h00000001, 4'hF, 1'b0, 32'h0,        32'h00000001, 4'hF, 1'b0, 2'd0, 16'd6, 16'd1};
    vecs[9] = '{2'd3, 32'h00000002, 4'hF, 1'b1, 32'h000000FF, 32'h00000002, 4'hF, 1'b1, 2'd0, 16'd7, 16'd0};

    @(negedge clk);
    check("rst_tready", 32'(s_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(m_valid), 32'h0);
    check("rst_tdata", m_data, 32'h0);
    check("rst_tkeep_tlast", {27'h0, m_keep, m_last}, 32'h0);
    check("rst_level", 32'(fifo_level), 32'h0);
    check("rst_counts", {pkt_count, beat_count}, 32'h0);
    check("rst_active", 32'(active_mode), 32'h0);
    @(negedge clk);
    aresetn = 1;
    m_ready = 1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mode = vecs[i].mode; s_data = vecs[i].data; s_keep = vecs[i].keep;
      s_last = vecs[i].last; cval = vecs[i].cval; s_valid = 1;
      if (i != 1) check($sformatf("v%0d_tready", i), 32'(s_ready), 32'h1);
      @(negedge clk);
      s_valid = 0;
      if (i == 1) mode = 2'd2;
      check($sformatf("v%0d_tvalid", i), 32'(m_valid), 32'h1);
      check($sformatf("v%0d_tdata", i), m_data, vecs[i].exp_data);
      check($sformatf("v%0d_tkeep", i), 32'(m_keep), 32'(vecs[i].exp_keep));
      check($sformatf("v%0d_tlast", i), 32'(m_last), 32'(vecs[i].exp_last));
      check($sformatf("v%0d_active", i), 32'(active_mode), 32'(vecs[i].exp_active));
      check($sformatf("v%0d_pkt", i), 32'(pkt_count), 32'(vecs[i].exp_pkt));
      check($sformatf("v%0d_beat", i), 32'(beat_count), 32'(vecs[i].exp_beat));
    end

    // Backpressure: fill FIFO with beats 1..4, hold, then drain while 5 and 6 trickle in.
    @(negedge clk);
    m_ready = 0; mode = 2'd0; s_keep = 4'hF; s_last = 0; s_valid = 1;
    for (int k = 1; k <= 4; k++) begin
      s_data = 32'(k);
      @(posedge clk);
      #1;
    end
    s_data = 32'd5;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      check("bp_full_tready", 32'(s_ready), 32'h0);
      check("bp_full_level", 32'(fifo_level), 32'd4);
      check("bp_hold_tdata", m_data, 32'd1);
      @(posedge clk);
      #1;
    end
    m_ready = 1;
    got = 1; nxt = 5;
    for (int c = 0; c < 40 && got <= 6; c++) begin
      @(negedge clk);
      if (m_valid) begin
        check("bp_order", m_data, 32'(got));
        got++;
      end
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        nxt++;
        if (nxt > 6) s_valid = 0;
        else begin s_data = 32'(nxt); s_last = (nxt == 6); end
      end
    end
    check("bp_delivered", 32'(got), 32'd7);
    @(negedge clk);
    check("bp_drained_level", 32'(fifo_level), 32'h0);
    check("bp_pkt", 32'(pkt_count), 32'd8);

    // Reset mid-packet with two buffered beats, then a fresh packet latches its own mode.
    m_ready = 0; mode = 2'd2; cval = 32'h1; s_last = 0; s_valid = 1; s_data = 32'h100;
    repeat (2) @(negedge clk);
    s_valid = 0;
    check("mid_level", 32'(fifo_level), 32'd2);
    aresetn = 0;
    #1;
    check("mid_rst_tready", 32'(s_ready), 32'h0);
    @(negedge clk);
    check("mid_tvalid", 32'(m_valid), 32'h0);
    check("mid_tdata", m_data, 32'h0);
    check("mid_level0", 32'(fifo_level), 32'h0);
    check("mid_counts", {pkt_count, beat_count}, 32'h0);
    aresetn = 1;
    m_ready = 1; mode = 2'd3; cval = 32'hF0; s_data = 32'h0F; s_last = 1; s_valid = 1;
    @(negedge clk);
    s_valid = 0;
    check("post_tdata", m_data, 32'hFF);
    check("post_active", 32'(active_mode), 32'd3);
    check("post_pkt", 32'(pkt_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
